// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and saturating-arithmetic helpers for MAC stages
package arith_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  typedef struct packed {
    logic ovf;
    logic signed [63:0] sum;
  } sat_t;
  function automatic logic signed [63:0] smax(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] smin(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
  function automatic sat_t sat_add(logic signed [63:0] a, logic signed [63:0] b, int w);
    logic signed [63:0] s;
    s = a + b;
    return s > smax(w) ? {1'b1, smax(w)} : s < smin(w) ? {1'b1, smin(w)} : {1'b0, s};
  endfunction
endpackage

// File: rtl/booth_product_accumulator_if.sv
// booth_product_accumulator_if: product-in / result-out handshakes plus abort
interface booth_product_accumulator_if #(
  parameter int PW = 8,
  parameter int ACC_W = 12,
  parameter int NTERMS = 4
);
  logic clear;
  logic prod_valid;
  logic prod_ready;
  logic signed [PW-1:0] prod_data;
  logic sum_valid;
  logic sum_ready;
  logic sum_ovf;
  logic signed [ACC_W-1:0] sum_data;
  logic [$clog2(NTERMS+1)-1:0] term_cnt;
  modport master (
    output clear, prod_valid, prod_data, sum_ready,
    input prod_ready, sum_valid, sum_data, sum_ovf, term_cnt
  );
  modport slave (
    input clear, prod_valid, prod_data, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_ovf, term_cnt
  );
endinterface

// File: rtl/booth_product_accumulator_sat_adder.sv
// sat_adder: combinational W-bit signed add that clamps to the W-bit range and flags it
module sat_adder
  import arith_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  localparam logic signed [W:0] MAX = (W+1)'(smax(W));
  localparam logic signed [W:0] MIN = (W+1)'(smin(W));
  logic signed [W:0] s;
  assign s = (W+1)'(a) + (W+1)'(b);
  assign ovf = s > MAX || s < MIN;
  assign sum = s > MAX ? MAX[W-1:0] : s < MIN ? MIN[W-1:0] : s[W-1:0];
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums NTERMS signed products into a saturating result
module booth_product_accumulator
  import arith_pkg::*;
#(
  parameter int PW = 8,
  parameter int ACC_W = 12,
  parameter int NTERMS = 4
) (
  input logic clk,
  input logic rst,
  booth_product_accumulator_if.slave bus
);
  localparam int CW = $clog2(NTERMS + 1);
  state_t state, state_n;
  logic signed [PW-1:0] pd;
  logic signed [ACC_W-1:0] acc, acc_n, ext, add_sum;
  logic [CW-1:0] cnt, cnt_n;
  logic ovf, ovf_n, add_ovf, accept;
  assign pd = bus.prod_data;
  assign ext = ACC_W'(pd);
  sat_adder #(.W(ACC_W)) u_add (.a(acc), .b(ext), .sum(add_sum), .ovf(add_ovf));
  assign accept = bus.prod_valid && state != HOLD;
  assign bus.prod_ready = state != HOLD;
  assign bus.sum_valid = state == HOLD;
  assign bus.sum_data = acc;
  assign bus.sum_ovf = ovf;
  assign bus.term_cnt = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
    end
  end
  // A result handoff and an abort both land in a clean IDLE; a product offered then is void.
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    if (bus.clear || (state == HOLD && bus.sum_ready)) begin
      state_n = IDLE;
      acc_n = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
    end else if (accept) begin
      acc_n = add_sum;
      ovf_n = ovf | add_ovf;
      cnt_n = cnt + 1'b1;
      state_n = cnt == CW'(NTERMS - 1) ? HOLD : ACCUM;
    end
  end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: three configurations checked against a transaction-level model
module tb_booth_product_accumulator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic rs[3], cl[3], pv[3], sr[3];
  logic [7:0] pd[3];
  int acc[3], n[3];
  bit hold[3], ov[3];
  int W[3] = '{12, 8, 12};
  int N[3] = '{4, 4, 1};
  booth_product_accumulator_if #(.PW(8), .ACC_W(12), .NTERMS(4)) b0();
  booth_product_accumulator_if #(.PW(8), .ACC_W(8), .NTERMS(4)) b1();
  booth_product_accumulator_if #(.PW(8), .ACC_W(12), .NTERMS(1)) b2();
  assign b0.clear = cl[0];
  assign b0.prod_valid = pv[0];
  assign b0.prod_data = pd[0];
  assign b0.sum_ready = sr[0];
  assign b1.clear = cl[1];
  assign b1.prod_valid = pv[1];
  assign b1.prod_data = pd[1];
  assign b1.sum_ready = sr[1];
  assign b2.clear = cl[2];
  assign b2.prod_valid = pv[2];
  assign b2.prod_data = pd[2];
  assign b2.sum_ready = sr[2];
  booth_product_accumulator #(.PW(8), .ACC_W(12), .NTERMS(4)) dut0 (.clk(clk), .rst(rs[0]), .bus(b0.slave));
  booth_product_accumulator #(.PW(8), .ACC_W(8), .NTERMS(4)) dut1 (.clk(clk), .rst(rs[1]), .bus(b1.slave));
  booth_product_accumulator #(.PW(8), .ACC_W(12), .NTERMS(1)) dut2 (.clk(clk), .rst(rs[2]), .bus(b2.slave));

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int o_ready(int i);
    return i == 0 ? int'(b0.prod_ready) : i == 1 ? int'(b1.prod_ready) : int'(b2.prod_ready);
  endfunction
  function automatic int o_valid(int i);
    return i == 0 ? int'(b0.sum_valid) : i == 1 ? int'(b1.sum_valid) : int'(b2.sum_valid);
  endfunction
  function automatic int o_ovf(int i);
    return i == 0 ? int'(b0.sum_ovf) : i == 1 ? int'(b1.sum_ovf) : int'(b2.sum_ovf);
  endfunction
  function automatic int o_cnt(int i);
    return i == 0 ? int'(b0.term_cnt) : i == 1 ? int'(b1.term_cnt) : int'(b2.term_cnt);
  endfunction
  function automatic int o_data(int i);
    return i == 0 ? int'(b0.sum_data) : i == 1 ? int'(b1.sum_data) : int'(b2.sum_data);
  endfunction

  // Reference: a running clamped sum of accepted products, handed over after N of them.
  task automatic model(int i);
    int lim, t;
    lim = 1 << (W[i] - 1);
    if (rs[i] || cl[i] || (hold[i] && sr[i])) begin
      acc[i] = 0;
      n[i] = 0;
      hold[i] = 0;
      ov[i] = 0;
    end else if (!hold[i] && pv[i]) begin
      t = acc[i] + int'($signed(pd[i]));
      if (t > lim - 1) begin
        t = lim - 1;
        ov[i] = 1;
      end else if (t < -lim) begin
        t = -lim;
        ov[i] = 1;
      end
      acc[i] = t;
      n[i]++;
      hold[i] = n[i] == N[i];
    end
  endtask

  task automatic compare(int i);
    string p;
    p = $sformatf("d%0d", i);
    check({p, "_ready"}, o_ready(i), int'(!hold[i]));
    check({p, "_valid"}, o_valid(i), int'(hold[i]));
    check({p, "_cnt"}, o_cnt(i), n[i]);
    if (hold[i] || n[i] == 0) check({p, "_ovf"}, o_ovf(i), int'(ov[i]));
    if (hold[i]) check({p, "_data"}, o_data(i), acc[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) compare(i);
  endtask

  task automatic put(int i, bit v, int d, bit s);
    pv[i] = v;
    pd[i] = 8'(d);
    sr[i] = s;
  endtask

  task automatic feed(int i, int a, int b, int c, int d, bit s);
    int v[4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      put(i, 1, v[k], s);
      tick();
    end
  endtask

  initial begin
    int ref_data;
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1;
      cl[i] = 0;
      put(i, 0, 0, 0);
      acc[i] = 0;
      n[i] = 0;
      hold[i] = 0;
      ov[i] = 0;
    end
    tick();
    for (int i = 0; i < 3; i++) rs[i] = 0;
    check("rst_ready", o_ready(0), 1);
    check("rst_valid", o_valid(0), 0);
    feed(0, 10, -3, 7, 20, 1);
    check("t1_valid", o_valid(0), 1);
    check("t1_sum", o_data(0), 34);
    check("t1_ovf", o_ovf(0), 0);
    put(0, 0, 0, 1);
    tick();
    check("t1_pulse", o_valid(0), 0);
    feed(1, 127, 127, -128, 5, 0);
    check("t2_sum", o_data(1), 4);
    check("t2_ovf", o_ovf(1), 1);
    put(1, 0, 0, 1);
    tick();
    put(1, 0, 0, 0);
    feed(0, 30, -40, 50, -60, 0);
    ref_data = o_data(0);
    check("t3_sum", ref_data, -20);
    for (int k = 0; k < 5; k++) begin
      put(0, 1, 77, 0);
      tick();
      check("t3_bp_ready", o_ready(0), 0);
      check("t3_bp_data", o_data(0), ref_data);
    end
    put(0, 1, 9, 1);
    tick();
    check("t3_rel_cnt", o_cnt(0), 0);
    check("t3_rel_ready", o_ready(0), 1);
    feed(0, 2, 3, 4, 5, 0);
    check("t3_next_sum", o_data(0), 14);
    put(0, 0, 0, 1);
    tick();
    put(0, 1, 5, 0);
    tick();
    put(0, 1, 6, 0);
    tick();
    check("t4_cnt2", o_cnt(0), 2);
    cl[0] = 1;
    put(0, 1, 99, 0);
    tick();
    cl[0] = 0;
    check("t4_clr_cnt", o_cnt(0), 0);
    check("t4_clr_ready", o_ready(0), 1);
    feed(0, 1, 1, 1, 1, 0);
    check("t4_sum", o_data(0), 4);
    put(0, 0, 0, 1);
    tick();
    feed(0, 3, 3, 3, 3, 0);
    check("t5_hold", o_valid(0), 1);
    rs[0] = 1;
    put(0, 1, 50, 1);
    tick();
    rs[0] = 0;
    check("t5_valid", o_valid(0), 0);
    check("t5_cnt", o_cnt(0), 0);
    check("t5_ready", o_ready(0), 1);
    check("t5_ovf", o_ovf(0), 0);
    put(0, 0, 0, 0);
    tick();
    put(2, 1, -5, 0);
    tick();
    check("t6_sum1", o_data(2), -5);
    check("t6_cnt1", o_cnt(2), 1);
    put(2, 0, 0, 1);
    tick();
    put(2, 0, 0, 0);
    tick();
    put(2, 1, 6, 1);
    tick();
    check("t6_sum2", o_data(2), 6);
    check("t6_cnt2", o_cnt(2), 1);
    put(2, 0, 0, 1);
    tick();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rs[i] = $urandom_range(127) == 0;
        cl[i] = $urandom_range(23) == 0;
        put(i, $urandom_range(3) != 0, int'($urandom_range(255)), $urandom_range(1) == 1);
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
